// File: rtl/rst_req.sv
// Reset-request generator: merges a debounced push-button, a software strobe and a watchdog
// timeout into one stretched active-low reset request, and records the cause of the last one.

module rst_req #(
    parameter int unsigned DEB_BITS  = 20,
    parameter int unsigned WDT_BITS  = 24,
    parameter int unsigned PULSE_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       sw_rst_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       rst_out_n,
    output logic [1:0] rst_cause,
    output logic       busy
);

    localparam int unsigned PulseW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PulseW-1:0] PulseLoad = PulseW'(PULSE_LEN - 1);

    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseBtn  = 2'b01;
    localparam logic [1:0] CauseWdt  = 2'b10;
    localparam logic [1:0] CauseSw   = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAssert = 2'b01,
        StHold   = 2'b10
    } state_e;

    state_e              state_q;
    logic                sync1_q;
    logic                btn_s_q;
    logic                deb_level_q;
    logic [DEB_BITS-1:0] deb_cnt_q;
    logic [WDT_BITS-1:0] wdt_cnt_q;
    logic [PulseW-1:0]   pulse_cnt_q;
    logic                rst_out_n_q;
    logic [1:0]          rst_cause_q;

    logic deb_differ;
    logic deb_expire;
    logic btn_event;
    logic wdt_run;
    logic wdt_event;
    logic sw_event;
    logic any_event;

    assign deb_differ = (btn_s_q != deb_level_q);
    assign deb_expire = deb_differ && (&deb_cnt_q);
    // The debounced level falls on this same edge, so the event is its 1-to-0 transition.
    assign btn_event  = deb_expire && !btn_s_q;

    assign wdt_run    = (state_q == StIdle) && wdt_en && !wdt_kick;
    assign wdt_event  = wdt_run && (&wdt_cnt_q);
    assign sw_event   = (state_q == StIdle) && sw_rst_req;
    assign any_event  = btn_event || wdt_event || sw_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            btn_s_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            btn_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level_q <= 1'b1;
            deb_cnt_q   <= '0;
        end else if (!deb_differ) begin
            deb_cnt_q   <= '0;
        end else if (deb_expire) begin
            deb_level_q <= btn_s_q;
            deb_cnt_q   <= '0;
        end else begin
            deb_cnt_q   <= deb_cnt_q + DEB_BITS'(1);
        end
    end

    // A kick on the all-ones cycle clears wdt_run, so it wins over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q <= '0;
        end else if (!wdt_run || wdt_event) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_q + WDT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rst_out_n_q <= 1'b1;
            rst_cause_q <= CauseNone;
            pulse_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_event) begin
                        state_q     <= StAssert;
                        rst_out_n_q <= 1'b0;
                        pulse_cnt_q <= PulseLoad;
                        if (btn_event) begin
                            rst_cause_q <= CauseBtn;
                        end else if (wdt_event) begin
                            rst_cause_q <= CauseWdt;
                        end else begin
                            rst_cause_q <= CauseSw;
                        end
                    end
                end
                StAssert: begin
                    if (pulse_cnt_q == '0) begin
                        rst_out_n_q <= 1'b1;
                        state_q     <= deb_level_q ? StIdle : StHold;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - PulseW'(1);
                    end
                end
                StHold: begin
                    if (deb_level_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    rst_out_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_cause = rst_cause_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rst_req.sv
// Bench for rst_req: a cycle model pushes expected outputs to a queue at each edge; they are
// popped and compared against the DUT just after the edge, plus directed scenario checks.

module tb_rst_req;

    localparam int unsigned DEB_BITS  = 4;
    localparam int unsigned WDT_BITS  = 6;
    localparam int unsigned PULSE_LEN = 8;
    localparam int DebMax = 15;
    localparam int WdtMax = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       rst_out_n;
    logic [1:0] rst_cause;
    logic       busy;

    rst_req #(
        .DEB_BITS (DEB_BITS),
        .WDT_BITS (WDT_BITS),
        .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .sw_rst_req(sw_rst_req),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .rst_out_n (rst_out_n),
        .rst_cause (rst_cause),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: st 0 idle, 1 assert, 2 hold.
    int m_s1, m_s2, m_lvl, m_dcnt, m_wcnt, m_pcnt, m_st, m_cause;
    bit m_out;

    logic [3:0] exp_q[$];

    int pulses = 0;
    int low_cycles = 0;
    bit prev_out = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  old_s2, old_lvl;
        bit  b_ev, w_ev, s_ev;
        if (rst) begin
            m_s1 = 1; m_s2 = 1; m_lvl = 1;
            m_dcnt = 0; m_wcnt = 0; m_pcnt = 0;
            m_st = 0; m_out = 1'b1; m_cause = 0;
            return;
        end
        old_s2  = m_s2;
        old_lvl = m_lvl;
        b_ev = (old_s2 != old_lvl) && (m_dcnt == DebMax) && (old_s2 == 0);
        w_ev = (m_st == 0) && wdt_en && !wdt_kick && (m_wcnt == WdtMax);
        s_ev = (m_st == 0) && sw_rst_req;

        if (old_s2 == old_lvl) m_dcnt = 0;
        else if (m_dcnt == DebMax) begin
            m_lvl  = old_s2;
            m_dcnt = 0;
        end else m_dcnt++;
        m_s2 = m_s1;
        m_s1 = int'(btn_n);

        if ((m_st == 0) && wdt_en && !wdt_kick) m_wcnt = (m_wcnt == WdtMax) ? 0 : m_wcnt + 1;
        else m_wcnt = 0;

        case (m_st)
            0: if (b_ev || w_ev || s_ev) begin
                m_st = 1;
                m_out = 1'b0;
                m_pcnt = PULSE_LEN - 1;
                m_cause = b_ev ? 1 : (w_ev ? 2 : 3);
            end
            1: if (m_pcnt == 0) begin
                m_out = 1'b1;
                m_st = (old_lvl == 0) ? 2 : 0;
            end else m_pcnt--;
            default: if (old_lvl == 1) m_st = 0;
        endcase
    endtask

    // One clock: model the edge, queue expectation, then compare just after the edge.
    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        model_edge();
        exp_q.push_back({m_out, 2'(m_cause), (m_st != 0)});
        #1;
        e = exp_q.pop_front();
        check("rst_out_n", 32'(rst_out_n), 32'(e[3]));
        check("rst_cause", 32'(rst_cause), 32'(e[2:1]));
        check("busy", 32'(busy), 32'(e[0]));
        if (prev_out && !rst_out_n) pulses++;
        if (!rst_out_n) low_cycles++;
        prev_out = rst_out_n;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_stats();
        pulses = 0;
        low_cycles = 0;
    endtask

    initial begin
        // 1: reset and quiet idle
        steps(2);
        rst = 1'b0;
        clear_stats();
        steps(200);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_cause", 32'(rst_cause), 32'd0);

        // 2: software strobe, second strobe during the pulse is ignored
        clear_stats();
        sw_rst_req = 1'b1;
        step();
        check("sw_first_low", 32'(rst_out_n), 32'd0);
        check("sw_busy", 32'(busy), 32'd1);
        sw_rst_req = 1'b0;
        steps(2);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        steps(20);
        check("sw_pulses", 32'(pulses), 32'd1);
        check("sw_low_len", 32'(low_cycles), 32'(PULSE_LEN));
        check("sw_cause", 32'(rst_cause), 32'd3);

        // 3: bouncing button, then a held press
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            btn_n = ~btn_n;
            steps(5);
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        btn_n = 1'b0;
        steps(40);
        check("btn_hold_busy", 32'(busy), 32'd1);
        check("btn_hold_out", 32'(rst_out_n), 32'd1);
        btn_n = 1'b1;
        steps(40);
        check("btn_pulses", 32'(pulses), 32'd1);
        check("btn_low_len", 32'(low_cycles), 32'(PULSE_LEN));
        check("btn_cause", 32'(rst_cause), 32'd1);
        check("btn_idle", 32'(busy), 32'd0);

        // 4: watchdog kicked, then starved, then kicked on the all-ones cycle
        clear_stats();
        wdt_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            steps(49);
            wdt_kick = 1'b1;
            step();
            wdt_kick = 1'b0;
        end
        check("wdt_kicked_pulses", 32'(pulses), 32'd0);
        steps(80);
        check("wdt_pulses", 32'(pulses), 32'd1);
        check("wdt_low_len", 32'(low_cycles), 32'(PULSE_LEN));
        check("wdt_cause", 32'(rst_cause), 32'd2);
        clear_stats();
        wdt_en = 1'b0;
        step();
        wdt_en = 1'b1;
        steps(WdtMax);
        check("wdt_at_max", 32'(dut.wdt_cnt_q), 32'(WdtMax));
        wdt_kick = 1'b1;
        step();
        wdt_kick = 1'b0;
        wdt_en = 1'b0;
        steps(5);
        check("wdt_kick_wins", 32'(pulses), 32'd0);

        // 5: button and software coincide, then rst aborts the pulse
        clear_stats();
        btn_n = 1'b0;
        steps(17);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check("coinc_low", 32'(rst_out_n), 32'd0);
        check("coinc_cause", 32'(rst_cause), 32'd1);
        steps(2);
        rst = 1'b1;
        step();
        check("abort_out", 32'(rst_out_n), 32'd1);
        check("abort_cause", 32'(rst_cause), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("coinc_pulses", 32'(pulses), 32'd1);
        rst = 1'b0;
        btn_n = 1'b1;
        steps(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
